dp_multicycle: RTL and testbench

Parametrised multicycle datapath for the J17 core: register file, ALU, branch/PC unit and a handshaked data-memory port, sequenced by an internal state machine. The decoder presents one decoded instruction at a time over a valid/ready handshake. The block executes the instruction, performs an optional load or store, writes back, and updates `PC`. Compared with the single-cycle datapath, it adds configurable width and register count, sign-extended immediates, wait-state memory, link writeback and divide-by-zero reporting.

---
 rtl/dp_pkg.sv | 86 ++++++++
 rtl/dp_alu.sv | 66 ++++++
 rtl/dp_multicycle.sv | 283 ++++++++++++++++++++++++++++
 tb/tb_dp_multicycle.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dp_pkg.sv
// -----------------------------------------------------------------------------
// dp_pkg
// Shared types and constants for the J17 multicycle datapath.
//   alu_op_e   : ALU operation codes (5 bit)
//   pc_ctl_e   : PC action / branch condition codes (3 bit)
//   wb_src_e   : writeback source select (2 bit)
//   mem_mode_e : data-memory access kind (2 bit)
//   dp_state_e : sequencer states
//   ERR_ALL_ONES : error pattern, sliced to the datapath width by users
//   branch_taken : branch decision from the unsigned compare flags
// -----------------------------------------------------------------------------
package dp_pkg;

    typedef enum logic [4:0] {
        ALU_PASS = 5'd0,
        ALU_ADD  = 5'd1,
        ALU_SUB  = 5'd2,
        ALU_MUL  = 5'd3,
        ALU_DIV  = 5'd4,
        ALU_MOD  = 5'd5,
        ALU_OR   = 5'd6,
        ALU_AND  = 5'd7,
        ALU_XOR  = 5'd8,
        ALU_NOT  = 5'd9,
        ALU_SHR  = 5'd10,
        ALU_SHL  = 5'd11
    } alu_op_e;

    typedef enum logic [2:0] {
        PC_INC = 3'd0,
        PC_EQ  = 3'd1,
        PC_LT  = 3'd2,
        PC_GT  = 3'd3,
        PC_NE  = 3'd4,
        PC_LE  = 3'd5,
        PC_GE  = 3'd6,
        PC_JMP = 3'd7
    } pc_ctl_e;

    typedef enum logic [1:0] {
        WB_ALU  = 2'd0,
        WB_OP2  = 2'd1,
        WB_LOAD = 2'd2,
        WB_LINK = 2'd3
    } wb_src_e;

    typedef enum logic [1:0] {
        MEM_NONE  = 2'd0,
        MEM_LOAD  = 2'd1,
        MEM_STORE = 2'd2,
        MEM_RSVD  = 2'd3
    } mem_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_MEM  = 2'd2,
        ST_WB   = 2'd3
    } dp_state_e;

    // Widest datapath supported by the shared error constant.
    localparam int ERR_MAX_W = 64;
    localparam logic [ERR_MAX_W-1:0] ERR_ALL_ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    // Branch decision from unsigned a-vs-b flags; gt is derived from eq/lt.
    function automatic logic branch_taken(input logic [2:0] ctl,
                                          input logic       eq,
                                          input logic       lt);
        logic gt;
        logic taken;
        gt = ~eq & ~lt;
        case (ctl)
            PC_INC:  taken = 1'b0;
            PC_EQ:   taken = eq;
            PC_LT:   taken = lt;
            PC_GT:   taken = gt;
            PC_NE:   taken = ~eq;
            PC_LE:   taken = lt | eq;
            PC_GE:   taken = ~lt;
            PC_JMP:  taken = 1'b1;
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/dp_alu.sv
// -----------------------------------------------------------------------------
// dp_alu
// Purely combinational ALU for the multicycle datapath. All operations are
// unsigned. Unknown codes and division/modulo by zero produce all-ones.
//   alucode  in  5       operation (alu_op_e)
//   a        in  DATA_W  operand 1
//   b        in  DATA_W  operand 2
//   result   out DATA_W  operation result
//   div_zero out 1       div/mod attempted with b == 0
// -----------------------------------------------------------------------------
module dp_alu
    import dp_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [4:0]        alucode,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] result,
    output logic              div_zero
);

    localparam logic [DATA_W-1:0] ONES = ERR_ALL_ONES[DATA_W-1:0];

    logic b_zero_s;

    assign b_zero_s = (b == {DATA_W{1'b0}});

    // Operation select; divide and modulo are guarded against a zero divisor.
    always_comb begin
        result   = ONES;
        div_zero = 1'b0;
        case (alucode)
            ALU_PASS: result = a;
            ALU_ADD:  result = a + b;
            ALU_SUB:  result = a - b;
            ALU_MUL:  result = a * b;
            ALU_DIV: begin
                if (b_zero_s) begin
                    result   = ONES;
                    div_zero = 1'b1;
                end else begin
                    result   = a / b;
                    div_zero = 1'b0;
                end
            end
            ALU_MOD: begin
                if (b_zero_s) begin
                    result   = ONES;
                    div_zero = 1'b1;
                end else begin
                    result   = a % b;
                    div_zero = 1'b0;
                end
            end
            ALU_OR:   result = a | b;
            ALU_AND:  result = a & b;
            ALU_XOR:  result = a ^ b;
            ALU_NOT:  result = ~a;
            ALU_SHR:  result = {1'b0, a[DATA_W-1:1]};
            ALU_SHL:  result = {a[DATA_W-2:0], 1'b0};
            default:  result = ONES;
        endcase
    end

endmodule

// File: rtl/dp_multicycle.sv
// -----------------------------------------------------------------------------
// dp_multicycle
// Multicycle datapath for the J17 core: register file, ALU, branch/PC unit and
// a handshaked data-memory port sequenced by IDLE -> EXEC -> (MEM) -> WB.
//   clock, reset_n           clock (rising edge), async active-low reset
//   instr_valid/instr_ready  decoded-instruction handshake (ready only in IDLE)
//   alucode, rd, rs2, imm,
//   im_control, reg_enable,
//   mem_mode, pc_control,
//   writecode                decoded instruction fields
//   mem_req/mem_we/mem_addr/
//   mem_wdata/mem_rdata/
//   mem_ack                  data-memory port; request held until ack
//   pc                       program counter
//   result, div_zero         registered ALU result / divide-by-zero flag
// -----------------------------------------------------------------------------
module dp_multicycle
    import dp_pkg::*;
#(
    parameter  int DATA_W = 32,
    parameter  int NREGS  = 8,
    parameter  int IMM_W  = 21,
    parameter  int ADDR_W = 10,
    localparam int RW     = $clog2(NREGS)
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [4:0]        alucode,
    input  logic [RW-1:0]     rd,
    input  logic [RW-1:0]     rs2,
    input  logic [IMM_W-1:0]  imm,
    input  logic              im_control,
    input  logic              reg_enable,
    input  logic [1:0]        mem_mode,
    input  logic [2:0]        pc_control,
    input  logic [1:0]        writecode,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [DATA_W-1:0] pc,
    output logic [DATA_W-1:0] result,
    output logic              div_zero
);

    localparam int                EXT_W  = DATA_W - IMM_W;
    localparam logic [DATA_W-1:0] PC_ONE = {{(DATA_W-1){1'b0}}, 1'b1};

    // Sequencer
    dp_state_e state_r;
    dp_state_e next_state_s;
    logic      accept_s;
    logic      exec_s;
    logic      mem_done_s;
    logic      wb_s;
    logic      mem_op_s;

    // Instruction latched at acceptance
    logic [DATA_W-1:0] a_r;
    logic [DATA_W-1:0] b_r;
    logic [DATA_W-1:0] imm_sext_r;
    logic [DATA_W-1:0] store_r;
    logic [4:0]        alucode_r;
    logic [RW-1:0]     rd_r;
    logic              reg_enable_r;
    logic [1:0]        mem_mode_r;
    logic [2:0]        pc_control_r;
    logic [1:0]        writecode_r;

    // Execution / writeback state
    logic [DATA_W-1:0] imm_sext_s;
    logic [DATA_W-1:0] alu_result_s;
    logic              alu_div_zero_s;
    logic              taken_r;
    logic [DATA_W-1:0] load_r;
    logic [DATA_W-1:0] result_r;
    logic              div_zero_r;
    logic [DATA_W-1:0] pc_r;
    logic [DATA_W-1:0] pc_inc_s;
    logic [DATA_W-1:0] pc_next_s;
    logic [DATA_W-1:0] wb_data_s;
    logic [DATA_W-1:0] regs_r [NREGS];

    // Memory port and handshake registers
    logic              instr_ready_r;
    logic              mem_req_r;
    logic              mem_we_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [DATA_W-1:0] mem_wdata_r;

    assign imm_sext_s = {{EXT_W{imm[IMM_W-1]}}, imm};

    dp_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .alucode  (alucode_r),
        .a        (a_r),
        .b        (b_r),
        .result   (alu_result_s),
        .div_zero (alu_div_zero_s)
    );

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; reserved memory mode behaves like no access.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (instr_valid) begin
                    next_state_s = ST_EXEC;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_EXEC: begin
                if (mem_op_s) begin
                    next_state_s = ST_MEM;
                end else begin
                    next_state_s = ST_WB;
                end
            end
            ST_MEM: begin
                if (mem_ack) begin
                    next_state_s = ST_WB;
                end else begin
                    next_state_s = ST_MEM;
                end
            end
            ST_WB:   next_state_s = ST_IDLE;
            default: next_state_s = ST_IDLE;
        endcase
    end

    // State decode strobes used by the datapath registers.
    always_comb begin
        accept_s   = 1'b0;
        exec_s     = 1'b0;
        mem_done_s = 1'b0;
        wb_s       = 1'b0;
        mem_op_s   = (mem_mode_r == MEM_LOAD) || (mem_mode_r == MEM_STORE);
        case (state_r)
            ST_IDLE: accept_s   = instr_valid;
            ST_EXEC: exec_s     = 1'b1;
            ST_MEM:  mem_done_s = mem_ack;
            ST_WB:   wb_s       = 1'b1;
            default: wb_s       = 1'b0;
        endcase
    end

    // Handshake outputs registered from the next state so they track state_r.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            instr_ready_r <= 1'b1;
            mem_req_r     <= 1'b0;
        end else begin
            instr_ready_r <= (next_state_s == ST_IDLE);
            mem_req_r     <= (next_state_s == ST_MEM);
        end
    end

    // Operand and control capture at acceptance; store data is regs[rs2].
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            a_r          <= '0;
            b_r          <= '0;
            imm_sext_r   <= '0;
            store_r      <= '0;
            alucode_r    <= 5'd0;
            rd_r         <= '0;
            reg_enable_r <= 1'b0;
            mem_mode_r   <= 2'd0;
            pc_control_r <= 3'd0;
            writecode_r  <= 2'd0;
        end else if (accept_s) begin
            a_r          <= regs_r[rd];
            b_r          <= im_control ? imm_sext_s : regs_r[rs2];
            imm_sext_r   <= imm_sext_s;
            store_r      <= regs_r[rs2];
            alucode_r    <= alucode;
            rd_r         <= rd;
            reg_enable_r <= reg_enable;
            mem_mode_r   <= mem_mode;
            pc_control_r <= pc_control;
            writecode_r  <= writecode;
        end
    end

    // EXEC: register ALU outputs and the branch decision.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            result_r   <= '0;
            div_zero_r <= 1'b0;
            taken_r    <= 1'b0;
        end else if (exec_s) begin
            result_r   <= alu_result_s;
            div_zero_r <= alu_div_zero_s;
            taken_r    <= branch_taken(pc_control_r, (a_r == b_r), (a_r < b_r));
        end
    end

    // Memory address/data/direction set up in EXEC and frozen through MEM.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mem_we_r    <= 1'b0;
            mem_addr_r  <= '0;
            mem_wdata_r <= '0;
        end else if (exec_s && mem_op_s) begin
            mem_we_r    <= (mem_mode_r == MEM_STORE);
            mem_addr_r  <= a_r[ADDR_W-1:0] + imm_sext_r[ADDR_W-1:0];
            mem_wdata_r <= store_r;
        end
    end

    // Load data capture on the acknowledging MEM cycle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            load_r <= '0;
        end else if (mem_done_s) begin
            load_r <= mem_rdata;
        end
    end

    // PC arithmetic and writeback source select; link uses the pre-update pc+1.
    always_comb begin
        pc_inc_s  = pc_r + PC_ONE;
        pc_next_s = pc_inc_s;
        if (taken_r) begin
            pc_next_s = pc_r + imm_sext_r;
        end else begin
            pc_next_s = pc_inc_s;
        end
        wb_data_s = result_r;
        case (writecode_r)
            WB_ALU:  wb_data_s = result_r;
            WB_OP2:  wb_data_s = b_r;
            WB_LOAD: wb_data_s = (mem_mode_r == MEM_LOAD) ? load_r : {DATA_W{1'b0}};
            WB_LINK: wb_data_s = pc_inc_s;
            default: wb_data_s = result_r;
        endcase
    end

    // Register file; written only in WB, so the next accept sees the new value.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_r[i] <= '0;
            end
        end else if (wb_s && reg_enable_r) begin
            regs_r[rd_r] <= wb_data_s;
        end
    end

    // Program counter update in WB; wraps modulo 2^DATA_W.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pc_r <= '0;
        end else if (wb_s) begin
            pc_r <= pc_next_s;
        end
    end

    assign instr_ready = instr_ready_r;
    assign mem_req     = mem_req_r;
    assign mem_we      = mem_we_r;
    assign mem_addr    = mem_addr_r;
    assign mem_wdata   = mem_wdata_r;
    assign pc          = pc_r;
    assign result      = result_r;
    assign div_zero    = div_zero_r;

endmodule

// File: tb/tb_dp_multicycle.sv
// -----------------------------------------------------------------------------
// tb_dp_multicycle
// Directed scoreboard bench for dp_multicycle (default parameters). Stimulus
// pushes hand-computed completions and memory transactions into queues; a
// completion monitor and a memory model pop and compare independently.
// -----------------------------------------------------------------------------
module tb_dp_multicycle;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        instr_valid;
    logic        instr_ready;
    logic [4:0]  alucode;
    logic [2:0]  rd;
    logic [2:0]  rs2;
    logic [20:0] imm;
    logic        im_control;
    logic        reg_enable;
    logic [1:0]  mem_mode;
    logic [2:0]  pc_control;
    logic [1:0]  writecode;
    logic        mem_req;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic [31:0] pc;
    logic [31:0] result;
    logic        div_zero;

    logic resp_ack  = 1'b0;
    logic stray_ack = 1'b0;
    assign mem_ack = resp_ack | stray_ack;

    always #5 clock = ~clock;

    dp_multicycle dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .alucode     (alucode),
        .rd          (rd),
        .rs2         (rs2),
        .imm         (imm),
        .im_control  (im_control),
        .reg_enable  (reg_enable),
        .mem_mode    (mem_mode),
        .pc_control  (pc_control),
        .writecode   (writecode),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_ack     (mem_ack),
        .pc          (pc),
        .result      (result),
        .div_zero    (div_zero)
    );

    localparam logic [4:0] PASS = 5'd0, ADD = 5'd1, SUB = 5'd2, MUL = 5'd3, DIV = 5'd4,
                           MOD = 5'd5, OR_ = 5'd6, AND_ = 5'd7, XOR_ = 5'd8, NOT_ = 5'd9,
                           SHR = 5'd10, SHL = 5'd11, BAD = 5'd12;

    typedef struct {
        string       nm;
        logic [31:0] pc;
        logic [31:0] res;
        logic        dz;
        int          lat;
    } exp_t;

    typedef struct {
        string       nm;
        logic [9:0]  addr;
        logic        we;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          n;
        logic        abort;
    } mexp_t;

    exp_t  exp_q[$];
    mexp_t mem_q[$];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Completion monitor: a rising instr_ready marks a finished instruction.
    int   busy       = 0;
    logic prev_ready = 1'b1;
    always @(negedge clock) begin
        if (!reset_n) begin
            busy       = 0;
            prev_ready = instr_ready;
        end else begin
            if (!instr_ready) begin
                busy++;
            end else if (!prev_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_completion", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk({e.nm, "_pc"}, pc, e.pc);
                    chk({e.nm, "_result"}, result, e.res);
                    chk({e.nm, "_div_zero"}, {31'd0, div_zero}, {31'd0, e.dz});
                    chk({e.nm, "_latency"}, 32'(busy + 1), 32'(e.lat));
                end
                busy = 0;
            end
            prev_ready = instr_ready;
        end
    end

    // Memory model: checks request fields every cycle and acks on cycle n.
    int mc = 0;
    always @(negedge clock) begin
        if (mem_req) begin
            if (mem_q.size() == 0) begin
                chk("unexpected_mem_req", 32'd1, 32'd0);
                resp_ack = 1'b0;
            end else begin
                mc++;
                chk({mem_q[0].nm, "_addr"}, {22'd0, mem_addr}, {22'd0, mem_q[0].addr});
                chk({mem_q[0].nm, "_we"}, {31'd0, mem_we}, {31'd0, mem_q[0].we});
                chk({mem_q[0].nm, "_wdata"}, mem_wdata, mem_q[0].wdata);
                mem_rdata = mem_q[0].rdata;
                resp_ack  = (mc == mem_q[0].n);
            end
        end else begin
            resp_ack = 1'b0;
            if (mc != 0) begin
                if (!mem_q[0].abort) begin
                    chk({mem_q[0].nm, "_req_cycles"}, 32'(mc), 32'(mem_q[0].n));
                end
                void'(mem_q.pop_front());
                mc = 0;
            end
        end
    end

    // Issue one instruction; expected outcome is pushed before acceptance.
    task automatic issue(input string nm, input logic [4:0] alu, input logic [2:0] r_d,
                         input logic [2:0] r_s2, input logic [20:0] im, input logic imc,
                         input logic ren, input logic [1:0] mm, input logic [2:0] pcc,
                         input logic [1:0] wc, input logic [31:0] e_pc, input logic [31:0] e_res,
                         input logic e_dz, input int n_mem, input logic [9:0] e_addr,
                         input logic [31:0] e_wdata, input logic [31:0] rdat, input logic done);
        int   k;
        exp_t e;
        mexp_t m;
        k = 0;
        @(negedge clock);
        while (!instr_ready && k < 300) begin
            @(negedge clock);
            k++;
        end
        if (!instr_ready) begin
            chk({nm, "_accept_timeout"}, 32'd0, 32'd1);
        end
        alucode = alu; rd = r_d; rs2 = r_s2; imm = im; im_control = imc;
        reg_enable = ren; mem_mode = mm; pc_control = pcc; writecode = wc;
        instr_valid = 1'b1;
        if (done) begin
            e.nm = nm; e.pc = e_pc; e.res = e_res; e.dz = e_dz;
            e.lat = (n_mem > 0) ? 3 + n_mem : 3;
            exp_q.push_back(e);
        end
        if (n_mem > 0) begin
            m.nm = nm; m.addr = e_addr; m.we = (mm == 2'd2); m.wdata = e_wdata;
            m.rdata = rdat; m.n = n_mem; m.abort = !done;
            mem_q.push_back(m);
        end
        @(posedge clock);
        #1 instr_valid = 1'b0;
    endtask

    // Non-memory shorthand.
    task automatic op(input string nm, input logic [4:0] alu, input logic [2:0] r_d,
                      input logic [2:0] r_s2, input logic [20:0] im, input logic imc,
                      input logic ren, input logic [2:0] pcc, input logic [1:0] wc,
                      input logic [31:0] e_pc, input logic [31:0] e_res, input logic e_dz);
        issue(nm, alu, r_d, r_s2, im, imc, ren, 2'd0, pcc, wc, e_pc, e_res, e_dz,
              0, 10'd0, 32'd0, 32'd0, 1'b1);
    endtask

    initial begin
        int k;
        reset_n = 1'b0; instr_valid = 1'b0; alucode = 5'd0; rd = 3'd0; rs2 = 3'd0;
        imm = 21'd0; im_control = 1'b0; reg_enable = 1'b0; mem_mode = 2'd0;
        pc_control = 3'd0; writecode = 2'd0; mem_rdata = 32'd0;
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        chk("rst_pc", pc, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_div_zero", {31'd0, div_zero}, 32'd0);
        chk("rst_ready", {31'd0, instr_ready}, 32'd1);
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_mem_addr", {22'd0, mem_addr}, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);

        //   name       alu   rd    rs2   imm          imc   ren   pcc   wc     pc    result        dz
        op("add_r1",   ADD,  3'd1, 3'd0, 21'd5,       1'b1, 1'b1, 3'd0, 2'd0, 32'd1, 32'd5,        1'b0);
        op("pass_r1",  PASS, 3'd1, 3'd0, 21'd0,       1'b1, 1'b0, 3'd0, 2'd0, 32'd2, 32'd5,        1'b0);
        op("add_r2",   ADD,  3'd2, 3'd0, 21'd7,       1'b1, 1'b1, 3'd0, 2'd0, 32'd3, 32'd7,        1'b0);
        op("div_zero", DIV,  3'd2, 3'd0, 21'd0,       1'b1, 1'b0, 3'd0, 2'd0, 32'd4, 32'hFFFFFFFF, 1'b1);
        op("dz_clear", ADD,  3'd2, 3'd0, 21'd0,       1'b1, 1'b0, 3'd0, 2'd0, 32'd5, 32'd7,        1'b0);
        op("mod_zero", MOD,  3'd2, 3'd0, 21'd0,       1'b1, 1'b0, 3'd0, 2'd0, 32'd6, 32'hFFFFFFFF, 1'b1);
        op("sub",      SUB,  3'd2, 3'd0, 21'd3,       1'b1, 1'b0, 3'd0, 2'd0, 32'd7, 32'd4,        1'b0);
        op("add_r3",   ADD,  3'd3, 3'd0, 21'd9,       1'b1, 1'b1, 3'd0, 2'd0, 32'd8, 32'd9,        1'b0);
        op("add_r4",   ADD,  3'd4, 3'd0, 21'd9,       1'b1, 1'b1, 3'd0, 2'd0, 32'd9, 32'd9,        1'b0);
        op("mul",      MUL,  3'd2, 3'd0, 21'd3,       1'b1, 1'b0, 3'd0, 2'd0, 32'd10, 32'd21,      1'b0);
        op("beq_take", ADD,  3'd3, 3'd4, 21'h1FFFFC,  1'b0, 1'b0, 3'd1, 2'd0, 32'd6, 32'd18,       1'b0);
        op("dec_r4",   ADD,  3'd4, 3'd0, 21'h1FFFFF,  1'b1, 1'b1, 3'd0, 2'd0, 32'd7, 32'd8,        1'b0);
        op("div",      DIV,  3'd2, 3'd0, 21'd2,       1'b1, 1'b0, 3'd0, 2'd0, 32'd8, 32'd3,        1'b0);
        op("mod",      MOD,  3'd2, 3'd0, 21'd3,       1'b1, 1'b0, 3'd0, 2'd0, 32'd9, 32'd1,        1'b0);
        op("xor",      XOR_, 3'd3, 3'd0, 21'd5,       1'b1, 1'b0, 3'd0, 2'd0, 32'd10, 32'd12,      1'b0);
        op("beq_not",  SUB,  3'd3, 3'd4, 21'h1FFFFC,  1'b0, 1'b0, 3'd1, 2'd0, 32'd11, 32'd1,       1'b0);
        op("blt_take", OR_,  3'd4, 3'd3, 21'd3,       1'b0, 1'b0, 3'd2, 2'd0, 32'd14, 32'd9,       1'b0);
        op("bge_not",  AND_, 3'd4, 3'd3, 21'd3,       1'b0, 1'b0, 3'd6, 2'd0, 32'd15, 32'd8,       1'b0);
        op("bgt_take", NOT_, 3'd3, 3'd4, 21'd2,       1'b0, 1'b0, 3'd3, 2'd0, 32'd17, 32'hFFFFFFF6, 1'b0);
        op("bne_not",  SHR,  3'd3, 3'd0, 21'd9,       1'b1, 1'b0, 3'd4, 2'd0, 32'd18, 32'd4,       1'b0);
        op("ble_not",  SHL,  3'd3, 3'd0, 21'd5,       1'b1, 1'b0, 3'd5, 2'd0, 32'd19, 32'd18,      1'b0);
        op("bad_code", BAD,  3'd3, 3'd0, 21'd5,       1'b1, 1'b0, 3'd0, 2'd0, 32'd20, 32'hFFFFFFFF, 1'b0);
        op("r1_op2",   PASS, 3'd1, 3'd0, 21'd3,       1'b1, 1'b1, 3'd0, 2'd1, 32'd21, 32'd5,       1'b0);
        op("r5_op2",   PASS, 3'd5, 3'd0, 21'h00ABCD,  1'b1, 1'b1, 3'd0, 2'd1, 32'd22, 32'd0,       1'b0);

        //     name        alu   rd    rs2   imm     imc   ren   mm    pcc   wc    pc      result  dz    n  addr    wdata         rdata         done
        issue("store",    ADD,  3'd1, 3'd5, 21'd2,  1'b1, 1'b0, 2'd2, 3'd0, 2'd0, 32'd23, 32'd5,  1'b0, 4, 10'd5, 32'h0000ABCD, 32'd0,        1'b1);
        issue("load",     PASS, 3'd6, 3'd5, 21'd5,  1'b1, 1'b1, 2'd1, 3'd0, 2'd2, 32'd24, 32'd0,  1'b0, 1, 10'd5, 32'h0000ABCD, 32'h0000ABCD, 1'b1);
        op("pass_r6",  PASS, 3'd6, 3'd0, 21'd0,       1'b1, 1'b0, 3'd0, 2'd0, 32'd25, 32'h0000ABCD, 1'b0);
        issue("store_wb", ADD,  3'd7, 3'd5, 21'd8,  1'b1, 1'b1, 2'd2, 3'd0, 2'd0, 32'd26, 32'd8,  1'b0, 2, 10'd8, 32'h0000ABCD, 32'd0,        1'b1);
        op("pass_r7",  PASS, 3'd7, 3'd0, 21'd0,       1'b1, 1'b0, 3'd0, 2'd0, 32'd27, 32'd8,       1'b0);
        op("ld_nomem", PASS, 3'd7, 3'd0, 21'd0,       1'b1, 1'b1, 3'd0, 2'd2, 32'd28, 32'd8,       1'b0);
        op("pass_r7b", PASS, 3'd7, 3'd0, 21'd0,       1'b1, 1'b0, 3'd0, 2'd0, 32'd29, 32'd0,       1'b0);
        op("jmp_to4",  PASS, 3'd0, 3'd0, 21'h1FFFE7,  1'b1, 1'b0, 3'd7, 2'd0, 32'd4, 32'd0,        1'b0);
        op("link",     PASS, 3'd2, 3'd0, 21'd20,      1'b1, 1'b1, 3'd7, 2'd3, 32'd24, 32'd7,       1'b0);
        op("pass_r2",  PASS, 3'd2, 3'd0, 21'd0,       1'b1, 1'b0, 3'd0, 2'd0, 32'd25, 32'd5,       1'b0);
        op("jmp_to0",  PASS, 3'd0, 3'd0, 21'h1FFFE7,  1'b1, 1'b0, 3'd7, 2'd0, 32'd0, 32'd0,        1'b0);
        op("jmp_wrap", PASS, 3'd0, 3'd0, 21'h1FFFFF,  1'b1, 1'b0, 3'd7, 2'd0, 32'hFFFFFFFF, 32'd0, 1'b0);
        op("inc_wrap", PASS, 3'd0, 3'd0, 21'd0,       1'b1, 1'b0, 3'd0, 2'd0, 32'd0, 32'd0,        1'b0);
        op("pass_r3",  PASS, 3'd3, 3'd0, 21'd0,       1'b1, 1'b0, 3'd0, 2'd0, 32'd1, 32'd9,        1'b0);

        // Load that never gets acked; reset lands in the middle of MEM.
        issue("ld_abort", PASS, 3'd3, 3'd0, 21'd0,  1'b1, 1'b1, 2'd1, 3'd0, 2'd2, 32'd0,  32'd0,  1'b0, 1000, 10'd9, 32'd0, 32'h00001234, 1'b0);
        k = 0;
        while (!mem_req && k < 20) begin
            @(negedge clock);
            k++;
        end
        chk("abort_req_seen", {31'd0, mem_req}, 32'd1);
        @(negedge clock);
        #1 reset_n = 1'b0;
        #1;
        chk("abort_req_drop", {31'd0, mem_req}, 32'd0);
        chk("abort_pc", pc, 32'd0);
        chk("abort_ready", {31'd0, instr_ready}, 32'd1);
        chk("abort_result", result, 32'd0);
        @(negedge clock);
        @(negedge clock);
        reset_n   = 1'b1;
        stray_ack = 1'b1;
        repeat (3) begin
            @(negedge clock);
            chk("stray_pc", pc, 32'd0);
            chk("stray_ready", {31'd0, instr_ready}, 32'd1);
            chk("stray_mem_req", {31'd0, mem_req}, 32'd0);
        end
        stray_ack = 1'b0;
        op("post_r3",  PASS, 3'd3, 3'd0, 21'd0,       1'b1, 1'b0, 3'd0, 2'd0, 32'd1, 32'd0,        1'b0);
        op("post_r2",  PASS, 3'd2, 3'd0, 21'd0,       1'b1, 1'b0, 3'd0, 2'd0, 32'd2, 32'd0,        1'b0);

        k = 0;
        while ((exp_q.size() != 0 || mem_q.size() != 0) && k < 300) begin
            @(negedge clock);
            k++;
        end
        chk("drain_exp_q", 32'(exp_q.size()), 32'd0);
        chk("drain_mem_q", 32'(mem_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
